xy_reg_ctrl: RTL and testbench

Sequencing controller for the X and Y index registers of the 16-bit processor. It accepts one register-transfer command at a time and drives the `acc_op`/`load` strobes of both registers. A command copies either the accumulator or a memory read result into X or Y. Memory-sourced loads use a ready handshake with a bounded wait. The block sits between the instruction decoder (command side) and the X/Y register pair plus data-memory read port (datapath side).

---
 rtl/xy_ctrl_pkg.sv | 62 ++++++
 rtl/wait_timer.sv | 37 +++
 rtl/xy_reg_ctrl.sv | 106 ++++++++++
 tb/tb_xy_reg_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xy_ctrl_pkg.sv
// Shared definitions for the X/Y index register sequencer and the
// instruction decoder: command codes, FSM state encoding, the default
// memory-wait bound and the output decode helper.
package xy_ctrl_pkg;

   localparam logic [1:0] CMD_TAX = 2'b00;
   localparam logic [1:0] CMD_TAY = 2'b01;
   localparam logic [1:0] CMD_LDX = 2'b10;
   localparam logic [1:0] CMD_LDY = 2'b11;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_MEM_WAIT = 3'd1;
   localparam logic [2:0] ST_WRITE    = 3'd2;
   localparam logic [2:0] ST_DONE     = 3'd3;
   localparam logic [2:0] ST_ERROR    = 3'd4;

   localparam int DEFAULT_TIMEOUT = 15;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      MEM_WAIT = ST_MEM_WAIT,
      WRITE    = ST_WRITE,
      DONE     = ST_DONE,
      ERROR    = ST_ERROR
   } state_t;

   typedef struct packed {
      logic busy;
      logic mem_rd;
      logic x_acc_op;
      logic x_load;
      logic y_acc_op;
      logic y_load;
      logic done;
      logic error;
   } ctrl_out_t;

   // Moore output decode for a given state and latched command.
   function automatic ctrl_out_t out_decode(input state_t st, input logic [1:0] c);
      ctrl_out_t o;
      o        = '0;
      o.busy   = (st != IDLE);
      o.mem_rd = (st == MEM_WAIT);
      o.done   = (st == DONE);
      o.error  = (st == ERROR);
      if (st == WRITE) begin
         case (c)
            CMD_TAX: o.x_acc_op = 1'b1;
            CMD_TAY: o.y_acc_op = 1'b1;
            CMD_LDX: o.x_load   = 1'b1;
            default: o.y_load   = 1'b1;
         endcase
      end
      return o;
   endfunction

   // Smallest counter width able to hold t-1 (at least one bit).
   function automatic int cnt_width(input int t);
      return (t <= 2) ? 1 : $clog2(t);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait timer: down-counter reloaded with TIMEOUT_CYCLES-1 while
// clear is high, decremented while enable is high, saturating at zero.
// Ports:
//   clk, reset (async active-low)
//   clear   : reload the counter
//   enable  : count one wait cycle
//   expired : counter has reached zero (current cycle is the last allowed)
module wait_timer
   import xy_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = cnt_width(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= LOAD_VAL;
      end else if (clear) begin
         count <= LOAD_VAL;
      end else if (enable && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/xy_reg_ctrl.sv
// Sequencer for the X/Y index registers. Takes one transfer command at a
// time (TAX, TAY, LDX, LDY) and drives the acc_op/load strobes of both
// registers; memory loads wait for mem_ready with a bounded timeout.
// Ports:
//   clk, reset (async active-low)
//   start, cmd[1:0]       : command strobe and code from the decoder
//   mem_ready             : memory read data valid
//   busy, mem_rd          : status / memory read request
//   x_acc_op, x_load      : X register strobes
//   y_acc_op, y_load      : Y register strobes
//   done, error           : completion / timeout pulses
//
// state    | meaning
// IDLE     | waiting for start
// MEM_WAIT | memory read requested, waiting for mem_ready
// WRITE    | one strobe to the target register
// DONE     | completion pulse
// ERROR    | memory load timed out, no register write
module xy_reg_ctrl
   import xy_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic       mem_ready,
   output logic       busy,
   output logic       mem_rd,
   output logic       x_acc_op,
   output logic       x_load,
   output logic       y_acc_op,
   output logic       y_load,
   output logic       done,
   output logic       error
);

   state_t     state;
   logic [1:0] cmd_q;
   ctrl_out_t  outs;
   logic       tmr_expired;

   // Timer is held at its reload value everywhere outside MEM_WAIT, so it
   // is already cleared on the first MEM_WAIT cycle.
   wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state != MEM_WAIT),
      .enable  (state == MEM_WAIT),
      .expired (tmr_expired)
   );

   // Outputs are registered alongside the state transition so they are
   // exactly the decode of the state being entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cmd_q <= CMD_TAX;
         outs  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cmd_q <= cmd;
                  if (cmd[1]) begin
                     state <= MEM_WAIT;
                     outs  <= out_decode(MEM_WAIT, cmd);
                  end else begin
                     state <= WRITE;
                     outs  <= out_decode(WRITE, cmd);
                  end
               end
            end
            MEM_WAIT: begin
               // Ready takes priority over expiry in the last allowed cycle.
               if (mem_ready) begin
                  state <= WRITE;
                  outs  <= out_decode(WRITE, cmd_q);
               end else if (tmr_expired) begin
                  state <= ERROR;
                  outs  <= out_decode(ERROR, cmd_q);
               end
            end
            WRITE: begin
               state <= DONE;
               outs  <= out_decode(DONE, cmd_q);
            end
            default: begin
               state <= IDLE;
               outs  <= '0;
            end
         endcase
      end
   end

   assign busy     = outs.busy;
   assign mem_rd   = outs.mem_rd;
   assign x_acc_op = outs.x_acc_op;
   assign x_load   = outs.x_load;
   assign y_acc_op = outs.y_acc_op;
   assign y_load   = outs.y_load;
   assign done     = outs.done;
   assign error    = outs.error;

endmodule

// File: tb/tb_xy_reg_ctrl.sv
module tb_xy_reg_ctrl;
   import xy_ctrl_pkg::*;

   localparam int T = 4;

   logic       clk = 1'b1;
   logic       reset;
   logic       start;
   logic [1:0] cmd;
   logic       mem_ready;
   logic       busy, mem_rd, x_acc_op, x_load, y_acc_op, y_load, done, error;

   logic [15:0] acc_val  = '0;
   logic [15:0] data_val = '0;
   logic [15:0] x_reg    = '0;
   logic [15:0] y_reg    = '0;

   int n_checks = 0;
   int n_fail   = 0;

   xy_reg_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cmd       (cmd),
      .mem_ready (mem_ready),
      .busy      (busy),
      .mem_rd    (mem_rd),
      .x_acc_op  (x_acc_op),
      .x_load    (x_load),
      .y_acc_op  (y_acc_op),
      .y_load    (y_load),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   // Register pair on the datapath side, written by the strobes.
   always @(posedge clk) begin
      if (x_acc_op)    x_reg <= acc_val;
      else if (x_load) x_reg <= data_val;
      if (y_acc_op)    y_reg <= acc_val;
      else if (y_load) y_reg <= data_val;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] dut_outs();
      return {busy, mem_rd, x_acc_op, x_load, y_acc_op, y_load, done, error};
   endfunction

   // Expected output vector in cycle c from the event cycle numbers
   // (-1 = event never happens).
   function automatic logic [7:0] exp_outs(input int c, input logic [1:0] cm,
                                           input int wr, input int dn, input int er, input int mr);
      logic [7:0] e;
      int last;
      last = (dn > er) ? dn : er;
      e    = '0;
      e[7] = (c >= 1) && (c <= last);
      e[6] = (c >= 1) && (c <= mr);
      if (c == wr) begin
         case (cm)
            2'b00:   e[5] = 1'b1;
            2'b10:   e[4] = 1'b1;
            2'b01:   e[3] = 1'b1;
            default: e[2] = 1'b1;
         endcase
      end
      e[1] = (c == dn);
      e[0] = (c == er);
      return e;
   endfunction

   // Reference timing: event cycles from the command and the MEM_WAIT
   // cycle k in which mem_ready first goes high (0 = never).
   task automatic model(input logic [1:0] cm, input int k,
                        output int wr, output int dn, output int er, output int mr);
      if (!cm[1]) begin
         wr = 1; dn = 2; er = -1; mr = 0;
      end else if (k > 0) begin
         mr = k; wr = k + 1; dn = k + 2; er = -1;
      end else begin
         mr = T; wr = -1; dn = -1; er = T + 1;
      end
   endtask

   task automatic run_cmd(input string name, input logic [1:0] cm, input int k,
                          input logic [15:0] acc, input logic [15:0] data,
                          input int wr, input int dn, input int er, input int mr,
                          input logic [15:0] ex, input logic [15:0] ey, input bit noise);
      int last;
      last     = (dn > er) ? dn : er;
      acc_val  = acc;
      data_val = data;
      for (int c = 0; c <= last + 1; c++) begin
         @(negedge clk);
         check($sformatf("%s cycle %0d outputs", name, c),
               {8'h00, dut_outs()}, {8'h00, exp_outs(c, cm, wr, dn, er, mr)});
         if (c == 0) begin
            start = 1'b1;
            cmd   = cm;
         end else if (noise && c <= last) begin
            start = 1'($urandom_range(0, 1));
            cmd   = 2'($urandom_range(0, 3));
         end else begin
            start = 1'b0;
         end
         if (c >= 1 && c <= mr)  mem_ready = (c == k);
         else if (noise)         mem_ready = 1'($urandom_range(0, 1));
         else                    mem_ready = 1'b0;
      end
      start     = 1'b0;
      mem_ready = 1'b0;
      check($sformatf("%s X", name), x_reg, ex);
      check($sformatf("%s Y", name), y_reg, ey);
   endtask

   typedef struct {
      logic [1:0]  cm;
      int          k;
      logic [15:0] acc;
      logic [15:0] data;
      int          wr, dn, er, mr;
      logic [15:0] ex, ey;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int nxa, nya, nd;
      int wr, dn, er, mr;
      logic [1:0]  rcm;
      int          rk;
      logic [15:0] racc, rdata, mdl_x, mdl_y;

      tbl[0] = '{CMD_TAY, 0, 16'h0002, 16'h0000,  1,  2, -1, 0, 16'h0000, 16'h0002};
      tbl[1] = '{CMD_LDX, 3, 16'h0000, 16'h0001,  4,  5, -1, 3, 16'h0001, 16'h0002};
      tbl[2] = '{CMD_LDY, 0, 16'h0000, 16'h7777, -1, -1,  5, 4, 16'h0001, 16'h0002};
      tbl[3] = '{CMD_LDY, 4, 16'h0000, 16'hBEEF,  5,  6, -1, 4, 16'h0001, 16'hBEEF};
      tbl[4] = '{CMD_TAX, 0, 16'h1234, 16'h0000,  1,  2, -1, 0, 16'h1234, 16'hBEEF};
      tbl[5] = '{CMD_LDX, 1, 16'h0000, 16'h00AA,  2,  3, -1, 1, 16'h00AA, 16'hBEEF};
      tbl[6] = '{CMD_LDX, 0, 16'h0000, 16'h3333, -1, -1,  5, 4, 16'h00AA, 16'hBEEF};

      reset     = 1'b0;
      start     = 1'b0;
      cmd       = 2'b00;
      mem_ready = 1'b0;
      #20;
      check("reset outputs", {8'h00, dut_outs()}, 16'h0000);
      #5;
      reset = 1'b1;
      #1;
      check("after reset busy", {15'h0, busy}, 16'h0000);

      for (int i = 0; i < 7; i++) begin
         run_cmd($sformatf("vec%0d", i), tbl[i].cm, tbl[i].k, tbl[i].acc, tbl[i].data,
                 tbl[i].wr, tbl[i].dn, tbl[i].er, tbl[i].mr, tbl[i].ex, tbl[i].ey, 1'b0);
      end

      // Start during busy is ignored.
      acc_val = 16'h5555;
      nxa = 0; nya = 0; nd = 0;
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         nxa += int'(x_acc_op);
         nya += int'(y_acc_op);
         nd  += int'(done);
         start = (c <= 2);
         cmd   = (c == 0) ? CMD_TAX : CMD_TAY;
      end
      start = 1'b0;
      check("reject x_acc_op count", 16'(nxa), 16'd1);
      check("reject y_acc_op count", 16'(nya), 16'd0);
      check("reject done count", 16'(nd), 16'd1);
      check("reject X", x_reg, 16'h5555);
      check("reject Y", y_reg, 16'hBEEF);

      // Reset in the middle of MEM_WAIT.
      data_val = 16'hDEAD;
      @(negedge clk);
      start = 1'b1;
      cmd   = CMD_LDX;
      @(negedge clk);
      start = 1'b0;
      check("rst seq cycle1 outputs", {8'h00, dut_outs()}, 16'h00C0);
      @(negedge clk);
      check("rst seq cycle2 outputs", {8'h00, dut_outs()}, 16'h00C0);
      #1 reset = 1'b0;
      #1 check("rst seq async clear", {8'h00, dut_outs()}, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1 check("rst seq busy after release", {15'h0, busy}, 16'h0000);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("rst seq idle %0d outputs", c), {8'h00, dut_outs()}, 16'h0000);
         @(negedge clk);
      end
      check("rst seq X", x_reg, 16'h5555);

      // Randomized commands against the reference model, with ignored
      // start/mem_ready noise outside the states that sample them.
      mdl_x = 16'h5555;
      mdl_y = 16'hBEEF;
      for (int i = 0; i < 30; i++) begin
         rcm   = 2'($urandom_range(0, 3));
         rk    = $urandom_range(0, T);
         racc  = 16'($urandom);
         rdata = 16'($urandom);
         model(rcm, rk, wr, dn, er, mr);
         case (rcm)
            CMD_TAX: mdl_x = racc;
            CMD_TAY: mdl_y = racc;
            CMD_LDX: if (rk > 0) mdl_x = rdata;
            default: if (rk > 0) mdl_y = rdata;
         endcase
         run_cmd($sformatf("rnd%0d", i), rcm, rk, racc, rdata, wr, dn, er, mr,
                 mdl_x, mdl_y, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
